// File: rtl/pll_rcfg_pkg.sv
// Shared types and register map for the RAM-clock PLL reconfiguration sequencer.
package pll_rcfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR        = 3'd1,
        ST_GAP       = 3'd2,
        ST_PRST      = 3'd3,
        ST_WAIT_LOCK = 3'd4,
        ST_ERR       = 3'd5
    } state_t;

    // pll_cfg management register addresses
    localparam logic [5:0] REG_MODE  = 6'd0;
    localparam logic [5:0] REG_START = 6'd2;
    localparam logic [5:0] REG_N     = 6'd3;
    localparam logic [5:0] REG_M     = 6'd4;
    localparam logic [5:0] REG_C     = 6'd5;
    localparam logic [5:0] REG_K     = 6'd7;
    localparam logic [5:0] REG_BW    = 6'd8;
    localparam logic [5:0] REG_CP    = 6'd9;

    // Fixed data words: N counter bypassed, charge pump and bandwidth settings
    localparam logic [31:0] N_BYPASS = 32'h0001_0000;
    localparam logic [31:0] CP_VAL   = 32'd1;
    localparam logic [31:0] BW_VAL   = 32'd7;

endpackage

// File: rtl/pll_reconfig_seq_sync2.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;

    // Shift the async level through two flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/pll_reconfig_seq.sv
// Sequencer that reprograms the RAM-clock PLL over its Avalon-MM management
// port, pulses the PLL reset and waits for a stable lock, retrying on timeout.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  IDLE       | waiting for start
//  WR         | mgmt write for current step held until waitrequest low
//  GAP        | idle spacing after an accepted write
//  PRST       | pll_reset asserted
//  WAIT_LOCK  | counting consecutive synced lock cycles, timeout running
//  ERR        | all attempts timed out; error raised, back to IDLE
module pll_reconfig_seq
    import pll_rcfg_pkg::*;
#(
    parameter int GAP_CYCLES   = 7,
    parameter int RST_CYCLES   = 8,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 1000000,
    parameter int MAX_RETRY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] m_val,
    input  logic [31:0] k_val,
    input  logic [31:0] c0_val,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        mgmt_write,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        pll_reset,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  attempt
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int RST_W = $clog2(RST_CYCLES + 1);
    localparam int STB_W = $clog2(LOCK_STABLE + 1);
    localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [RST_W-1:0] RST_LOAD  = RST_W'(RST_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LOAD   = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STB_LAST  = STB_W'(LOCK_STABLE - 1);
    localparam logic [STB_W-1:0] STB_MAX   = STB_W'(LOCK_STABLE);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

    state_t            state_q, state_d;
    logic [2:0]        step_q;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic [RST_W-1:0]  rst_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [STB_W-1:0]  stable_cnt_q;
    logic [1:0]        attempt_q;
    logic [31:0]       m_q, k_q, c0_q;
    logic [31:0]       m_sh_q, k_sh_q, c0_sh_q;
    logic              pending_q, done_q, error_q;
    logic              lock_s;

    logic wr_accept, gap_end, rst_end, lock_timeout, lock_hit;
    logic can_retry, restart_req, run_over, start_now, rerun, retry;

    sync2 u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    assign wr_accept    = (state_q == ST_WR) && !mgmt_waitrequest;
    assign gap_end      = (state_q == ST_GAP) && (gap_cnt_q == '0);
    assign rst_end      = (state_q == ST_PRST) && (rst_cnt_q == '0);
    assign lock_timeout = (state_q == ST_WAIT_LOCK) && (to_cnt_q == '0);
    assign lock_hit     = (state_q == ST_WAIT_LOCK) && lock_s && (stable_cnt_q == STB_LAST);
    assign can_retry    = attempt_q < RETRY_MAX;
    // a start arriving in the finishing cycle counts as pending
    assign restart_req  = pending_q || start;
    // timeout wins over a same-cycle stable hit
    assign run_over     = lock_timeout ? !can_retry : lock_hit;
    assign start_now    = ((state_q == ST_IDLE) || (state_q == ST_ERR)) && start;
    assign rerun        = run_over && restart_req;
    assign retry        = lock_timeout && can_retry;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start) state_d = ST_WR;
            ST_WR:        if (wr_accept) state_d = ST_GAP;
            ST_GAP:       if (gap_end) state_d = (step_q == 3'd7) ? ST_PRST : ST_WR;
            ST_PRST:      if (rst_end) state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (lock_timeout)  state_d = (can_retry || restart_req) ? ST_WR : ST_ERR;
                else if (lock_hit) state_d = restart_req ? ST_WR : ST_IDLE;
            end
            ST_ERR:       state_d = start ? ST_WR : ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Step, timers, latched words, pending shadow and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q       <= '0;
            gap_cnt_q    <= '0;
            rst_cnt_q    <= '0;
            to_cnt_q     <= '0;
            stable_cnt_q <= '0;
            attempt_q    <= '0;
            m_q          <= '0;
            k_q          <= '0;
            c0_q         <= '0;
            m_sh_q       <= '0;
            k_sh_q       <= '0;
            c0_sh_q      <= '0;
            pending_q    <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            if (start && busy) begin
                pending_q <= 1'b1;
                m_sh_q    <= m_val;
                k_sh_q    <= k_val;
                c0_sh_q   <= c0_val;
            end
            if (start_now) begin
                m_q  <= m_val;
                k_q  <= k_val;
                c0_q <= c0_val;
            end else if (rerun) begin
                m_q       <= start ? m_val  : m_sh_q;
                k_q       <= start ? k_val  : k_sh_q;
                c0_q      <= start ? c0_val : c0_sh_q;
                pending_q <= 1'b0;
            end

            if (start_now || rerun || retry)       step_q <= '0;
            else if (gap_end && step_q != 3'd7)    step_q <= step_q + 3'd1;

            if (start_now || rerun) attempt_q <= '0;
            else if (retry)         attempt_q <= attempt_q + 2'd1;

            if (wr_accept)                                     gap_cnt_q <= GAP_LOAD;
            else if (state_q == ST_GAP && gap_cnt_q != '0)     gap_cnt_q <= gap_cnt_q - 1'b1;

            if (gap_end && step_q == 3'd7)                     rst_cnt_q <= RST_LOAD;
            else if (state_q == ST_PRST && rst_cnt_q != '0)    rst_cnt_q <= rst_cnt_q - 1'b1;

            if (rst_end)                                       to_cnt_q <= TO_LOAD;
            else if (state_q == ST_WAIT_LOCK && to_cnt_q != '0) to_cnt_q <= to_cnt_q - 1'b1;

            if (rst_end)                      stable_cnt_q <= '0;
            else if (state_q == ST_WAIT_LOCK) begin
                if (!lock_s)                       stable_cnt_q <= '0;
                else if (stable_cnt_q != STB_MAX)  stable_cnt_q <= stable_cnt_q + 1'b1;
            end

            done_q <= lock_hit && !lock_timeout && !restart_req;

            if (start_now)                                           error_q <= 1'b0;
            else if (lock_timeout && !can_retry && !restart_req)     error_q <= 1'b1;
        end
    end

    // Outputs: write strobe, step decode and status
    always_comb begin
        mgmt_write     = (state_q == ST_WR);
        pll_reset      = (state_q == ST_PRST);
        busy           = (state_q == ST_WR) || (state_q == ST_GAP) ||
                         (state_q == ST_PRST) || (state_q == ST_WAIT_LOCK);
        done           = done_q;
        error          = error_q;
        attempt        = attempt_q;
        mgmt_address   = '0;
        mgmt_writedata = '0;
        if (state_q == ST_WR) begin
            case (step_q)
                3'd0: begin mgmt_address = REG_MODE;  mgmt_writedata = 32'd0;    end
                3'd1: begin mgmt_address = REG_M;     mgmt_writedata = m_q;      end
                3'd2: begin mgmt_address = REG_K;     mgmt_writedata = k_q;      end
                3'd3: begin mgmt_address = REG_N;     mgmt_writedata = N_BYPASS; end
                3'd4: begin mgmt_address = REG_C;     mgmt_writedata = c0_q;     end
                3'd5: begin mgmt_address = REG_CP;    mgmt_writedata = CP_VAL;   end
                3'd6: begin mgmt_address = REG_BW;    mgmt_writedata = BW_VAL;   end
                3'd7: begin mgmt_address = REG_START; mgmt_writedata = 32'd0;    end
                default: begin mgmt_address = '0;     mgmt_writedata = '0;       end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: write order and spacing, waitrequest
// stalls, timeout retries, lock glitch, restart on pending start, async reset.
module tb_pll_reconfig_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0, start_b = 1'b0;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked = 1'b0;
    logic [31:0] m_val = '0, k_val = '0, c0_val = '0;

    logic        mgmt_write, pll_reset, busy, done, error;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic [1:0]  attempt;

    logic        b_write, b_pll_reset, b_busy, b_done, b_error;
    logic [5:0]  b_addr;
    logic [31:0] b_data;
    logic [1:0]  b_attempt;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
        int          c;
    } wr_t;

    wr_t        wq[$];
    logic [1:0] b_att[$];
    int cyc = 0, rst_hi = 0, b_wr = 0, b_done_cnt = 0;
    int errors = 0, checks = 0;
    int done_cnt, done_n, lock_n;

    pll_reconfig_seq u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .m_val            (m_val),
        .k_val            (k_val),
        .c0_val           (c0_val),
        .mgmt_waitrequest (mgmt_waitrequest),
        .pll_locked       (pll_locked),
        .mgmt_write       (mgmt_write),
        .mgmt_address     (mgmt_address),
        .mgmt_writedata   (mgmt_writedata),
        .pll_reset        (pll_reset),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .attempt          (attempt)
    );

    pll_reconfig_seq #(.LOCK_TIMEOUT(100)) u_dut_to (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start_b),
        .m_val            (m_val),
        .k_val            (k_val),
        .c0_val           (c0_val),
        .mgmt_waitrequest (1'b0),
        .pll_locked       (1'b0),
        .mgmt_write       (b_write),
        .mgmt_address     (b_addr),
        .mgmt_writedata   (b_data),
        .pll_reset        (b_pll_reset),
        .busy             (b_busy),
        .done             (b_done),
        .error            (b_error),
        .attempt          (b_attempt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe accepted writes and reset pulses mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (mgmt_write && !mgmt_waitrequest) wq.push_back('{mgmt_address, mgmt_writedata, cyc});
            if (pll_reset) rst_hi++;
            if (b_write) begin
                b_wr++;
                if (b_addr == 6'd0) b_att.push_back(b_attempt);
            end
            if (b_done) b_done_cnt++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] m, input logic [31:0] k, input logic [31:0] c);
        m_val = m; k_val = k; c0_val = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Models the PLL: lock drops during pll_reset, rises lock_delay cycles after it falls
    task automatic run_lock(input int lock_delay, input int budget);
        int  since;
        bit  armed;
        since = 0; armed = 0;
        done_cnt = 0; done_n = -1; lock_n = -1;
        for (int n = 1; n <= budget; n++) begin
            tick();
            if (done) begin
                done_cnt++;
                if (done_n < 0) done_n = n;
            end
            if (pll_reset) begin
                pll_locked = 1'b0; armed = 1; since = 0;
            end else if (armed) begin
                since++;
                if (since == lock_delay) begin
                    pll_locked = 1'b1; lock_n = n; armed = 0;
                end
            end
            if (done_n > 0 && n >= done_n + 5) break;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #20;
        checks++;
        if ({mgmt_write, pll_reset, busy, done, error} !== 5'b0)
            begin errors++; $display("FAIL reset_flags: got %b expected 00000", {mgmt_write, pll_reset, busy, done, error}); end
        checks++;
        if (mgmt_address !== 6'd0 || mgmt_writedata !== 32'd0 || attempt !== 2'd0)
            begin errors++; $display("FAIL reset_bus: addr=%0h data=%0h att=%0d expected 0", mgmt_address, mgmt_writedata, attempt); end
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if ({mgmt_write, pll_reset, busy, b_write, b_busy} !== 5'b0)
            begin errors++; $display("FAIL reset_idle: got %b expected 00000", {mgmt_write, pll_reset, busy, b_write, b_busy}); end
    endtask

    task automatic test_single_run();
        logic [5:0]  ea [8];
        logic [31:0] ed [8];
        ea = '{6'd0, 6'd4, 6'd7, 6'd3, 6'd5, 6'd9, 6'd8, 6'd2};
        ed = '{32'd0, 32'h123, 32'h8000_0001, 32'h1_0000, 32'h505, 32'd1, 32'd7, 32'd0};
        pll_locked = 1'b0; wq.delete(); rst_hi = 0;
        pulse_start(32'h123, 32'h8000_0001, 32'h505);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL run_busy: got %b expected 1", busy); end
        run_lock(50, 3000);
        checks++;
        if (wq.size() != 8) begin errors++; $display("FAIL run_nwrites: got %0d expected 8", wq.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i < wq.size()) begin
                if (wq[i].a !== ea[i] || wq[i].d !== ed[i])
                    begin errors++; $display("FAIL run_write%0d: got %0d:%0h expected %0d:%0h", i, wq[i].a, wq[i].d, ea[i], ed[i]); end
            end else begin
                errors++; $display("FAIL run_write%0d: got none expected %0d:%0h", i, ea[i], ed[i]);
            end
        end
        for (int i = 1; i < 8 && i < wq.size(); i++) begin
            checks++;
            if (wq[i].c - wq[i-1].c != 8)
                begin errors++; $display("FAIL run_spacing%0d: got %0d expected 8", i, wq[i].c - wq[i-1].c); end
        end
        checks++;
        if (rst_hi != 8) begin errors++; $display("FAIL run_rst_len: got %0d expected 8", rst_hi); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL run_done_cnt: got %0d expected 1", done_cnt); end
        checks++;
        if (done_n - lock_n != 1026) begin errors++; $display("FAIL run_done_lat: got %0d expected 1026", done_n - lock_n); end
        checks++;
        if ({busy, error, attempt} !== 4'b0)
            begin errors++; $display("FAIL run_end_state: busy=%b err=%b att=%0d expected 0", busy, error, attempt); end
    endtask

    task automatic test_waitrequest();
        bit found;
        int n7;
        pll_locked = 1'b0; wq.delete(); found = 0;
        pulse_start(32'h44, 32'hCAFE_0007, 32'h66);
        for (int n = 0; n < 100; n++) begin
            if (mgmt_write && mgmt_address == 6'd7) begin found = 1; break; end
            tick();
        end
        checks++;
        if (!found) begin errors++; $display("FAIL wr_find_step2: got none expected write to addr 7"); end
        mgmt_waitrequest = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (!(mgmt_write === 1'b1 && mgmt_address === 6'd7 && mgmt_writedata === 32'hCAFE_0007))
                begin errors++; $display("FAIL wr_hold%0d: got w=%b a=%0d d=%0h expected 1/7/cafe0007", i, mgmt_write, mgmt_address, mgmt_writedata); end
            tick();
            if (i == 4) mgmt_waitrequest = 1'b0;
        end
        checks++;
        if (mgmt_write !== 1'b0) begin errors++; $display("FAIL wr_drop: got %b expected 0", mgmt_write); end
        run_lock(50, 3000);
        n7 = 0;
        foreach (wq[i]) if (wq[i].a == 6'd7) n7++;
        checks++;
        if (n7 != 1) begin errors++; $display("FAIL wr_accepts: got %0d expected 1", n7); end
        checks++;
        if (wq.size() != 8 || wq[2].a !== 6'd7 || wq[3].a !== 6'd3 || wq[7].a !== 6'd2)
            begin errors++; $display("FAIL wr_sequence: got n=%0d expected 8 writes in order", wq.size()); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL wr_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_timeout_retry();
        bit found;
        logic [5:0] att_v;
        b_wr = 0; b_att.delete(); b_done_cnt = 0; found = 0;
        m_val = 32'h11; k_val = 32'h22; c0_val = 32'h33;
        start_b = 1'b1; tick(); start_b = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            tick();
            if (b_error) begin found = 1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL to_error: got error=0 expected 1 within budget"); end
        checks++;
        if (b_wr != 24) begin errors++; $display("FAIL to_nwrites: got %0d expected 24", b_wr); end
        att_v = 6'h3f;
        for (int i = 0; i < b_att.size() && i < 3; i++) att_v[i*2 +: 2] = b_att[i];
        checks++;
        if (b_att.size() != 3 || att_v !== 6'b10_01_00)
            begin errors++; $display("FAIL to_attempts: got n=%0d v=%b expected 3 / 100100", b_att.size(), att_v); end
        checks++;
        if (b_busy !== 1'b0 || b_done_cnt != 0)
            begin errors++; $display("FAIL to_busy_done: got busy=%b dones=%0d expected 0/0", b_busy, b_done_cnt); end
        repeat (5) tick();
        checks++;
        if (b_error !== 1'b1 || b_attempt !== 2'd2)
            begin errors++; $display("FAIL to_sticky: got err=%b att=%0d expected 1/2", b_error, b_attempt); end
    endtask

    task automatic test_lock_glitch();
        bit found;
        int dn;
        pll_locked = 1'b0; found = 0; dn = -1;
        pulse_start(32'h77, 32'h88, 32'h99);
        for (int n = 0; n < 200; n++) begin
            tick();
            if (pll_reset) begin found = 1; break; end
        end
        for (int n = 0; n < 20 && pll_reset; n++) tick();
        checks++;
        if (!found || pll_reset !== 1'b0) begin errors++; $display("FAIL gl_prst: got found=%0d rst=%b expected 1/0", found, pll_reset); end
        pll_locked = 1'b1;
        for (int n = 1; n <= 3000; n++) begin
            tick();
            if (done) begin dn = n; break; end
            if (n == 1000) pll_locked = 1'b0;
            if (n == 1001) pll_locked = 1'b1;
        end
        checks++;
        if (dn != 2027) begin errors++; $display("FAIL gl_done_lat: got %0d expected 2027", dn); end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL gl_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_back_to_back();
        pll_locked = 1'b0; wq.delete();
        pulse_start(32'h100, 32'h2100, 32'h300);
        for (int n = 0; n < 200; n++) begin
            tick();
            if (mgmt_write && mgmt_address == 6'd5) break;
        end
        tick(); tick();
        pulse_start(32'h150, 32'h2150, 32'h350);
        tick(); tick();
        pulse_start(32'h160, 32'h2160, 32'h360);
        run_lock(50, 5000);
        checks++;
        if (wq.size() != 16) begin errors++; $display("FAIL b2b_nwrites: got %0d expected 16", wq.size()); end
        checks++;
        if (wq.size() > 1 && wq[1].d !== 32'h100) begin errors++; $display("FAIL b2b_first_m: got %0h expected 100", wq[1].d); end
        checks++;
        if (wq.size() > 10 && (wq[9].a !== 6'd4 || wq[9].d !== 32'h160 || wq[10].d !== 32'h2160))
            begin errors++; $display("FAIL b2b_new_words: got %0d:%0h k=%0h expected 4:160 k=2160", wq[9].a, wq[9].d, wq[10].d); end
        checks++;
        if (done_cnt != 1 || error !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL b2b_done: got dones=%0d err=%b busy=%b expected 1/0/0", done_cnt, error, busy); end
    endtask

    task automatic test_async_reset();
        bit found;
        pll_locked = 1'b0; wq.delete(); found = 0;
        pulse_start(32'h5, 32'h6, 32'h7);
        for (int n = 0; n < 100; n++) begin
            if (mgmt_write && mgmt_address == 6'd3) begin found = 1; break; end
            tick();
        end
        checks++;
        if (!found) begin errors++; $display("FAIL ar_find_step3: got none expected write to addr 3"); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({mgmt_write, pll_reset, busy} !== 3'b0 || mgmt_address !== 6'd0 || mgmt_writedata !== 32'd0)
            begin errors++; $display("FAIL ar_async: got w=%b r=%b b=%b a=%0d d=%0h expected all 0", mgmt_write, pll_reset, busy, mgmt_address, mgmt_writedata); end
        #10 rst_n = 1'b1;
        repeat (40) tick();
        checks++;
        if (wq.size() != 3 || busy !== 1'b0 || mgmt_write !== 1'b0)
            begin errors++; $display("FAIL ar_idle: got writes=%0d busy=%b expected 3/0", wq.size(), busy); end
        pulse_start(32'h5, 32'h6, 32'h7);
        checks++;
        if (mgmt_write !== 1'b1 || mgmt_address !== 6'd0)
            begin errors++; $display("FAIL ar_restart: got w=%b a=%0d expected 1/0", mgmt_write, mgmt_address); end
    endtask

    initial begin
        test_reset();
        test_single_run();
        test_waitrequest();
        test_timeout_retry();
        test_lock_glitch();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
